// File: rtl/load_writeback.sv
// RV32 load unit: computes the effective address, checks alignment, issues one word read
// and writes the sign- or zero-extended result to the register file.
module load_writeback #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic [1:0]  dbg_state
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    f3_q, f3_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_d, done_d, fault_d, mem_req_d, we3_d;
  logic [31:0]   mem_addr_d, wd3_d;
  logic [4:0]    a3_d;
  logic          illegal;
  logic [31:0]   shifted;
  logic [15:0]   half;
  logic [31:0]   load_data;

  assign dbg_state = state_q;

  // Misaligned halfword/word accesses and the three unused funct3 codes all fault.
  always_comb begin
    illegal = 1'b0;
    case (f3_q)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = addr_q[0];
      3'b010:         illegal = (addr_q[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
  end

  always_comb begin
    shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
    half      = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{half[15]}}, half};
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b101:  load_data = {16'b0, half};
      default: load_data = mem_rdata;
    endcase
  end

  // valid/ready: start is taken only while busy=0; mem_req holds with a stable mem_addr
  // until mem_ack is sampled high in REQ, and mem_ack in any other state is dropped.
  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    busy_d     = busy;
    done_d     = 1'b0;
    fault_d    = 1'b0;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    we3_d      = 1'b0;
    a3_d       = a3;
    wd3_d      = wd3;
    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d    = funct3;
          rd_d    = rd;
          addr_d  = base + offset;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (illegal) begin
          fault_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = {addr_q[31:2], 2'b00};
          cnt_d      = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          we3_d     = (rd_q != 5'd0);
          done_d    = 1'b1;
          a3_d      = rd_q;
          wd3_d     = load_data;
          state_d   = WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      f3_q     <= 3'b0;
      rd_q     <= 5'b0;
      addr_q   <= 32'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= 32'b0;
      we3      <= 1'b0;
      a3       <= 5'b0;
      wd3      <= 32'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      fault    <= fault_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      we3      <= we3_d;
      a3       <= a3_d;
      wd3      <= wd3_d;
    end
  end

endmodule

// File: tb/tb_load_writeback.sv
// Directed bench for load_writeback: formatting, alignment faults, timeout, reset abort.
module tb_load_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] base, offset;
  logic [4:0]  rd;
  logic        busy, done, fault, mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  load_writeback #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .base(base),
    .offset(offset), .rd(rd), .busy(busy), .done(done), .fault(fault),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .we3(we3), .a3(a3), .wd3(wd3), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"}, {31'b0, busy}, 32'd0);
    check({tag, ".done"}, {31'b0, done}, 32'd0);
    check({tag, ".fault"}, {31'b0, fault}, 32'd0);
    check({tag, ".mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, ".we3"}, {31'b0, we3}, 32'd0);
  endtask

  // Called at a negedge with busy=0; returns at the negedge where busy has fallen again.
  task automatic load_ok(input string tag, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [4:0] r, input int wait_cycles,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wd);
    start = 1'b1; funct3 = f3; base = b; offset = o; rd = r;
    @(negedge clk);
    check({tag, ".busy_accept"}, {31'b0, busy}, 32'd1);
    check({tag, ".state_check"}, {30'b0, dbg_state}, 32'd1);
    // Second start while busy, plus a stray ack in CHECK: both must be dropped.
    rd = r ^ 5'h1f; base = 32'hFFFF0000; funct3 = 3'b011; mem_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
    check({tag, ".mem_req"}, {31'b0, mem_req}, 32'd1);
    check({tag, ".mem_addr"}, mem_addr, exp_addr);
    check({tag, ".no_fault"}, {31'b0, fault}, 32'd0);
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      check({tag, ".req_held"}, {31'b0, mem_req}, 32'd1);
      check({tag, ".addr_held"}, mem_addr, exp_addr);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = $urandom;
    check({tag, ".we3"}, {31'b0, we3}, (r != 5'd0) ? 32'd1 : 32'd0);
    check({tag, ".done"}, {31'b0, done}, 32'd1);
    check({tag, ".a3"}, {27'b0, a3}, {27'b0, r});
    check({tag, ".wd3"}, wd3, exp_wd);
    check({tag, ".req_dropped"}, {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    check_idle_outputs({tag, ".after"});
  endtask

  task automatic load_fault(input string tag, input logic [2:0] f3, input logic [31:0] b,
                            input logic [31:0] o);
    start = 1'b1; funct3 = f3; base = b; offset = o; rd = 5'd7;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, ".fault"}, {31'b0, fault}, 32'd1);
    check({tag, ".mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, ".we3"}, {31'b0, we3}, 32'd0);
    check({tag, ".busy_low"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    check_idle_outputs({tag, ".after"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'b0; base = 32'b0; offset = 32'b0;
    rd = 5'b0; mem_ack = 1'b0; mem_rdata = 32'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset.a3", {27'b0, a3}, 32'd0);
    check("reset.wd3", wd3, 32'd0);
    check("reset.mem_addr", mem_addr, 32'd0);
    check("reset.state", {30'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    load_ok("lw",  3'b010, 32'h100, 32'd4, 5'd5, 2, 32'hDEADBEEF, 32'h104, 32'hDEADBEEF);
    load_ok("lb",  3'b000, 32'h200, 32'd3, 5'd9, 0, 32'h80FF1234, 32'h200, 32'hFFFFFF80);
    load_ok("lbu", 3'b100, 32'h200, 32'd3, 5'd9, 1, 32'h80FF1234, 32'h200, 32'h00000080);
    load_ok("lb1", 3'b000, 32'h200, 32'd1, 5'd3, 0, 32'h80FF1234, 32'h200, 32'h00000012);
    load_ok("lh",  3'b001, 32'h310, 32'hFFFFFFF2, 5'd12, 1, 32'h80017FFF, 32'h300, 32'hFFFF8001);
    load_ok("lhu", 3'b101, 32'h300, 32'd2, 5'd31, 0, 32'h80017FFF, 32'h300, 32'h00008001);
    load_ok("lh0", 3'b001, 32'h300, 32'd0, 5'd4, 0, 32'h80017FFF, 32'h300, 32'h00007FFF);
    load_ok("lw_rd0", 3'b010, 32'h400, 32'd0, 5'd0, 1, 32'h12345678, 32'h400, 32'h12345678);

    load_fault("lw_mis", 3'b010, 32'h100, 32'd2);
    load_fault("lh_mis", 3'b001, 32'h301, 32'd0);
    load_fault("f3_011", 3'b011, 32'h100, 32'd0);
    load_fault("f3_111", 3'b111, 32'h100, 32'd0);

    // No ack: mem_req must stay high for exactly four cycles, then fault.
    start = 1'b1; funct3 = 3'b010; base = 32'h40; offset = 32'd0; rd = 5'd6;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tmo.req_high", {31'b0, mem_req}, 32'd1);
      check("tmo.no_fault_yet", {31'b0, fault}, 32'd0);
    end
    @(negedge clk);
    check("tmo.req_low", {31'b0, mem_req}, 32'd0);
    check("tmo.fault", {31'b0, fault}, 32'd1);
    check("tmo.we3", {31'b0, we3}, 32'd0);
    check("tmo.done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check_idle_outputs("tmo.after");

    // Reset while in REQ, then a late ack.
    start = 1'b1; funct3 = 3'b010; base = 32'h80; offset = 32'd0; rd = 5'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst.req_before", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("rst.async");
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    check_idle_outputs("rst.late_ack");
    check("rst.wd3", wd3, 32'd0);
    load_ok("post_rst", 3'b010, 32'h80, 32'd0, 5'd8, 0, 32'hCAFEF00D, 32'h80, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_writeback.md
LOAD_WRITEBACK -- requirements
Module: load_writeback

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles mem_req is held without mem_ack before a fault is raised.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-high.
REQ-004 start  input  1  load request strobe, accepted only while busy=0.
REQ-005 funct3  input  3  RV32 load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 base  input  32  rs1 value.
REQ-007 offset  input  32  sign-extended I-immediate.
REQ-008 rd  input  5  destination register index.
REQ-009 busy  output  1  high from accept until return to IDLE.
REQ-010 done  output  1  one-cycle pulse on successful completion.
REQ-011 fault  output  1  one-cycle pulse on misaligned, illegal or timed-out load.
REQ-012 mem_req  output  1  memory read request.
REQ-013 mem_addr  output  32  word-aligned read address.
REQ-014 mem_ack  input  1  memory response valid; mem_rdata is valid in the same cycle.
REQ-015 mem_rdata  input  32  memory read word, little-endian.
REQ-016 we3, a3, wd3  output  1/5/32  register-file write port.

Function
REQ-017 The FSM SHALL have the states IDLE, CHECK, REQ, WB; all outputs SHALL be registered.
REQ-018 IDLE: start=1 -> latch funct3, rd, addr=(base+offset) mod 2^32; go to CHECK; busy=1 from the next cycle.
REQ-019 start while busy=1 SHALL be ignored, with no effect on latched values.
REQ-020 CHECK: illegal funct3 (011/110/111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 -> fault pulse, no mem_req, return to IDLE.
REQ-021 CHECK, legal: go to REQ with mem_req=1 and mem_addr={addr[31:2],2'b00}.
REQ-022 REQ: mem_req and mem_addr SHALL be held stable until mem_ack=1 is sampled.
REQ-023 REQ, on mem_ack: capture mem_rdata, drop mem_req the next cycle, go to WB.
REQ-024 Byte select: byte addr[1:0] of the word (bits 8*addr[1:0]+7..8*addr[1:0]).
REQ-025 Halfword select: half addr[1] of the word.
REQ-026 Extension: LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-027 WB: assert we3 for exactly one cycle with a3=rd and wd3=formatted data; assert done in the same cycle; return to IDLE.
REQ-028 rd=0: we3 SHALL stay 0 in WB; done SHALL still pulse.
REQ-029 REQ: an 8-bit+ wait counter SHALL increment each cycle without ack; on reaching TIMEOUT -> drop mem_req, fault pulse, no we3, return to IDLE.
REQ-030 mem_ack outside REQ SHALL be ignored.
REQ-031 Latency: start at cycle 0 -> CHECK at 1 -> mem_req at 2; ack at cycle k -> we3/done at k+1.
REQ-032 Back-to-back: a new start SHALL be accepted in the cycle busy returns to 0.

Reset
REQ-033 While reset=1: state=IDLE; busy, done, fault, mem_req, we3=0; a3, wd3, mem_addr=0; wait counter=0.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately with no we3, done or fault pulse; a late mem_ack after reset SHALL be ignored.

Verification
REQ-035 LW base=0x100, offset=4, rd=5, ack after 3 cycles with rdata=0xDEADBEEF -> mem_addr=0x104; we3=1, a3=5, wd3=0xDEADBEEF, done pulse.
REQ-036 LB addr=0x203, rdata=0x80FF1234 -> wd3=0xFFFFFF80; the same load as LBU -> wd3=0x00000080.
REQ-037 LH addr=0x302, rdata=0x8001_7FFF -> wd3=0xFFFF8001; LHU -> 0x00008001.
REQ-038 LW addr=0x102, and funct3=011 -> fault pulse 1 cycle after CHECK, mem_req never asserted, no we3.
REQ-039 No ack with TIMEOUT=4 -> mem_req high for 4 cycles then low, fault pulse, no we3; LW to rd=0 -> done pulse, we3 stays 0.
REQ-040 Reset pulsed while in REQ, followed by mem_ack -> all outputs 0, no we3/done/fault; the next start completes normally.
